// File: rtl/req_priority_sched.sv
// ============================================================================
// Module      : req_priority_sched
// Description : 4-requester scheduler (fixed-priority or round-robin) with
//               grant hold, hold timeout and encoded {x,y,V} owner output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_priority_sched #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic             rr_mode,
  output logic [3:0]       grant,
  output logic             x,
  output logic             y,
  output logic             V,
  output logic             timeout,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [0:0]       c_ST_IDLE   = 1'b0;
  localparam logic [0:0]       c_ST_GRANT  = 1'b1;
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       r_state;
  logic [1:0]       r_owner;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_hold;
  logic [3:0]       r_grant;
  logic             r_x;
  logic             r_y;
  logic             r_v;
  logic             r_timeout;

  logic [0:0]       w_state_nxt;
  logic [1:0]       w_owner_nxt;
  logic [1:0]       w_last_nxt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [3:0]       w_grant_nxt;
  logic             w_timeout_nxt;

  logic             w_owner_req;
  logic             w_expired;
  logic             w_hold_on;
  logic [3:0]       w_elig;
  logic [1:0]       w_idx;
  logic [1:0]       w_win;
  logic             w_win_vld;

  assign w_owner_req = req[r_owner];
  assign w_expired   = (r_state == c_ST_GRANT) && w_owner_req && (r_hold == c_HOLD_LAST);
  assign w_hold_on   = (r_state == c_ST_GRANT) && w_owner_req && !w_expired;
  // A timed-out owner sits out the arbitration on its own release edge.
  assign w_elig      = w_expired ? (req & ~(4'b0001 << r_owner)) : req;

  // Arbitration: later loop iterations override earlier ones, so the loops
  // run from lowest to highest precedence.
  always_comb begin
    w_win     = 2'd0;
    w_win_vld = 1'b0;
    w_idx     = 2'd0;
    if (rr_mode) begin
      for (int k = 3; k >= 0; k--) begin
        w_idx = r_last + 2'(k + 1);
        if (w_elig[w_idx]) begin
          w_win     = w_idx;
          w_win_vld = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_elig[i]) begin
          w_win     = 2'(i);
          w_win_vld = 1'b1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_ST_IDLE;
      r_owner   <= 2'd0;
      r_last    <= 2'd3;
      r_hold    <= '0;
      r_grant   <= 4'b0000;
      r_x       <= 1'b0;
      r_y       <= 1'b0;
      r_v       <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_last    <= w_last_nxt;
      r_hold    <= w_hold_nxt;
      r_grant   <= w_grant_nxt;
      r_x       <= w_grant_nxt[3] | w_grant_nxt[2];
      r_y       <= w_grant_nxt[3] | w_grant_nxt[1];
      r_v       <= |w_grant_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = c_ST_IDLE;
    case (r_state)
      c_ST_IDLE: begin
        if (w_win_vld) w_state_nxt = c_ST_GRANT;
      end
      c_ST_GRANT: begin
        if (w_hold_on || w_win_vld) w_state_nxt = c_ST_GRANT;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output / datapath logic (values registered on the next edge)
  always_comb begin
    w_owner_nxt   = r_owner;
    w_last_nxt    = r_last;
    w_hold_nxt    = '0;
    w_timeout_nxt = 1'b0;
    if (w_hold_on) begin
      w_hold_nxt = r_hold + CNT_W'(1);
    end else begin
      w_timeout_nxt = w_expired;
      if (w_win_vld) begin
        w_owner_nxt = w_win;
        w_last_nxt  = w_win;
      end
    end
    w_grant_nxt = (w_state_nxt == c_ST_GRANT) ? (4'b0001 << w_owner_nxt) : 4'b0000;
  end

  assign grant    = r_grant;
  assign x        = r_x;
  assign y        = r_y;
  assign V        = r_v;
  assign timeout  = r_timeout;
  assign hold_cnt = r_hold;

endmodule

`default_nettype wire

// File: tb/tb_req_priority_sched.sv
// ============================================================================
// Module      : tb_req_priority_sched
// Description : Directed self-checking bench for req_priority_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_req_priority_sched;

  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic             rr_mode;
  logic [3:0]       grant;
  logic             x;
  logic             y;
  logic             V;
  logic             timeout;
  logic [CNT_W-1:0] hold_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model: owner (-1 = idle), last owner, cycles held - 1, timeout.
  int m_owner = -1;
  int m_last  = 3;
  int m_cnt   = 0;
  bit m_to    = 1'b0;

  req_priority_sched #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .rr_mode  (rr_mode),
    .grant    (grant),
    .x        (x),
    .y        (y),
    .V        (V),
    .timeout  (timeout),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input logic rr, input int last, input int excl);
    int order[4];
    for (int k = 0; k < 4; k++) order[k] = rr ? (last + 1 + k) % 4 : 3 - k;
    for (int k = 0; k < 4; k++) if (r[order[k]] && order[k] != excl) return order[k];
    return -1;
  endfunction

  function automatic bit held_req(input int o, input logic [3:0] r);
    return (o >= 0) && r[o];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= 3;
      m_cnt   <= 0;
      m_to    <= 1'b0;
    end else if (held_req(m_owner, req) && m_cnt < MAX_HOLD - 1) begin
      m_cnt <= m_cnt + 1;
      m_to  <= 1'b0;
    end else begin
      m_to    <= held_req(m_owner, req);
      m_cnt   <= 0;
      m_owner <= pick(req, rr_mode, m_last, held_req(m_owner, req) ? m_owner : -1);
      if (pick(req, rr_mode, m_last, held_req(m_owner, req) ? m_owner : -1) >= 0)
        m_last <= pick(req, rr_mode, m_last, held_req(m_owner, req) ? m_owner : -1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("m_grant",   32'(grant),    (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
      chk("m_x",       32'(x),        32'(m_owner == 3 || m_owner == 2));
      chk("m_y",       32'(y),        32'(m_owner == 3 || m_owner == 1));
      chk("m_V",       32'(V),        32'(m_owner >= 0));
      chk("m_timeout", 32'(timeout),  32'(m_to));
      chk("m_hold",    32'(hold_cnt), 32'(m_cnt));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    rst_n   = 1'b1;
    req     = 4'b0000;
    rr_mode = 1'b0;
    #3 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_V",     32'(V),     32'd0);
    chk("rst_hold",  32'(hold_cnt), 32'd0);
    cyc(2);
    rst_n = 1'b1;

    // Fixed priority, back-to-back handover
    req = 4'b0111;
    cyc(1);
    chk("fx_grant0", 32'(grant), 32'h4);
    chk("fx_xyv0",   32'({x, y, V}), 32'b101);
    req = 4'b0011;
    cyc(1);
    chk("fx_grant1", 32'(grant), 32'h2);
    chk("fx_xyv1",   32'({x, y, V}), 32'b011);
    req = 4'b0000;
    cyc(2);

    // Timeout with no contender
    req = 4'b1000;
    for (int i = 0; i < MAX_HOLD; i++) begin
      cyc(1);
      chk("to_grant", 32'(grant), 32'h8);
      chk("to_hold",  32'(hold_cnt), 32'(i));
    end
    cyc(1);
    chk("to_pulse", 32'({timeout, grant}), 32'h10);
    cyc(1);
    chk("to_regrant", 32'({timeout, grant}), 32'h08);
    req = 4'b0000;
    cyc(2);

    // Timeout with contender
    req = 4'b1001;
    cyc(MAX_HOLD + 1);
    chk("toc_hand", 32'({timeout, grant}), 32'h11);
    cyc(MAX_HOLD);
    chk("toc_back", 32'({timeout, grant}), 32'h18);
    req = 4'b0000;
    cyc(2);

    // No preemption
    req = 4'b0001;
    cyc(1);
    req = 4'b1001;
    cyc(3);
    chk("np_hold", 32'(grant), 32'h1);
    req = 4'b1000;
    cyc(1);
    chk("np_next", 32'(grant), 32'h8);
    req = 4'b0000;
    cyc(2);

    // Round-robin rotation
    rr_mode = 1'b1;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    req = 4'b1111;
    cyc(1);
    chk("rr_grant0", 32'(grant), 32'(rr_exp[0]));
    for (int k = 1; k < 5; k++) begin
      cyc(1);
      req = 4'b1111 & ~rr_exp[k-1];
      cyc(1);
      chk("rr_grant", 32'(grant), 32'(rr_exp[k]));
      req = 4'b1111;
    end
    req = 4'b0000;
    rr_mode = 1'b0;
    cyc(2);

    // Asynchronous reset mid-grant
    req = 4'b0001;
    cyc(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_grant", 32'(grant), 32'd0);
    chk("ar_xyv",   32'({x, y, V, timeout}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    req = 4'b0000;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/req_priority_sched.md
Name: req_priority_sched

Overview:
- Clocked scheduler that shares one downstream resource among 4 requesters. The resource is fed by our 4-to-2 priority encoder datapath.
- Arbitrates each cycle in fixed-priority mode (D[3] highest) or round-robin mode.
- Holds a grant until the owner releases it, or until a hold timeout forces release.
- Presents the winner as a one-hot grant and as the encoder-style code {x,y} plus valid V.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant (legal range 2..15).
- CNT_W, 4, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines; req[i]=1 means requester i wants the resource.
- rr_mode  input  1  0 = fixed priority (3>2>1>0); 1 = round-robin.
- grant  output  4  one-hot grant (all-zero when idle).
- x  output  1  grant code bit 1 (1 when owner is 3 or 2).
- y  output  1  grant code bit 0 (1 when owner is 3 or 1).
- V  output  1  grant valid; equals |grant.
- timeout  output  1  one-cycle pulse on a forced release.
- hold_cnt  output  CNT_W  cycles the current owner has held the grant, minus 1.

Behaviour:
- Reset (async, rst_n=0): grant=0, x=y=V=0, timeout=0, hold_cnt=0, state=IDLE, last_owner=3.
  - Reset mid-grant drops the grant immediately, without waiting for a clock.
- All outputs are registered. Grant latency is 1 cycle: req sampled at edge k produces a grant visible after edge k.
- Encoding: owner 3 -> x,y = 1,1; owner 2 -> 1,0; owner 1 -> 0,1; owner 0 -> 0,0. When idle, x = y = 0 and V = 0.
- Arbitration function (used at every arbitration edge):
  - Fixed mode: highest-index asserted eligible req wins.
  - RR mode: search order starts at (last_owner+1) mod 4 and wraps; the first asserted eligible req wins.
  - last_owner updates to the winner on every new grant.
  - rr_mode is sampled only at arbitration edges; changing it mid-grant has no effect on the current owner.
- States:
  - IDLE:
    - If any req is set: go to GRANT, load grant per the arbitration function, hold_cnt=0.
    - Otherwise stay in IDLE with outputs at 0.
  - GRANT (owner o):
    - Hold while req[o]=1 and hold_cnt<MAX_HOLD-1; hold_cnt increments by 1 each cycle.
    - Normal release when req[o]=0 is sampled: re-arbitrate on the same edge among the remaining reqs.
      - If another req wins, it is granted with no idle gap and hold_cnt=0.
      - If none, go to IDLE.
    - Forced release when req[o]=1 and hold_cnt==MAX_HOLD-1:
      - timeout=1 for exactly one cycle.
      - Re-arbitrate on the same edge with o excluded.
      - If no other req, go to IDLE for at least 1 cycle; o may win again from IDLE.
- Simultaneous events:
  - New reqs arriving while GRANT is held are ignored until release; there is no preemption, even by a higher priority.
  - Release and a new req on the same edge yield back-to-back grants.
- grant is always one-hot or zero. V==|grant at all times.
- hold_cnt never exceeds MAX_HOLD-1 and never wraps.

Test Plan:
- Reset: rst_n=0 asserted asynchronously during a grant -> grant=0000, V=0, x=y=0, timeout=0 before the next clk edge.
- Fixed priority: rr_mode=0, req=0111 -> after 1 edge grant=0100, x,y=1,0, V=1. Then req=0011 -> next edge grant=0010, x,y=0,1, with no idle cycle.
- Round-robin: rr_mode=1, req=1111 held, each owner drops its req for 1 cycle after 2 grant cycles -> grant order 0001, 0010, 0100, 1000, 0001.
- Timeout: MAX_HOLD=8, req=1000 held continuously -> grant=1000 for 8 cycles with hold_cnt 0..7. Then timeout=1 for one cycle, grant=0000 for 1 cycle, then grant=1000 again.
- Timeout with contender: req=1001 held, fixed mode -> owner 3 for 8 cycles, timeout pulse, grant=0001 on the same edge, then 8 cycles later grant=1000.
- No preemption: grant=0001 held with req=0001; raise req to 1001 -> grant stays 0001 until req[0] drops, then grant=1000 on the next edge.
